// File: rtl/branch_pkg.sv
// ============================================================================
// Module : branch_pkg
// Shared opcodes, BHT counter encoding and helpers for the branch unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RST = WNT;

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op == OP_BEQZ) || (op == OP_BNEZ) || (op == OP_BLTZ) || (op == OP_BGEZ);
  endfunction

  function automatic logic bht_predicts_taken(input bht_state_t s);
    return (s == WT) || (s == ST);
  endfunction

  // Saturating up/down step of a 2-bit counter.
  function automatic bht_state_t bht_train(input bht_state_t s, input logic taken);
    case (s)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// Module : branch_cond_eval
// Combinational BEQZ/BNEZ/BLTZ/BGEZ decode and condition evaluation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        opcode_i,
  input  logic [DATA_W-1:0] rs_i,
  output logic              is_branch_o,
  output logic              taken_o
);

  assign is_branch_o = is_branch_op(opcode_i);

  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OP_BEQZ: taken_o = (rs_i == '0);
      OP_BNEZ: taken_o = (rs_i != '0);
      OP_BLTZ: taken_o = rs_i[DATA_W-1];
      OP_BGEZ: taken_o = ~rs_i[DATA_W-1];
      default: taken_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module : branch_predict_unit
// Branch resolve plus PC-indexed 2-bit BHT predictor; statistics counters
// exist only when BRANCH_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic [4:0]        pred_opcode,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [4:0]        res_opcode,
  input  logic [DATA_W-1:0] res_rs,
  input  logic              res_pred_taken,
  output logic              res_taken,
  output logic              mispredict,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_state_t       bht_q [ENTRIES];
  bht_state_t       bht_wr_d;
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             res_is_branch;
  logic             res_cond;
  logic             train;

  // Halfword-aligned instructions: bit 0 of the PC carries no information.
  assign pred_idx = pred_pc[IDX_W:1];
  assign res_idx  = res_pc[IDX_W:1];

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .opcode_i    (res_opcode),
    .rs_i        (res_rs),
    .is_branch_o (res_is_branch),
    .taken_o     (res_cond)
  );

  assign train      = res_valid & res_is_branch;
  assign res_taken  = train & res_cond;
  assign mispredict = train & (res_taken != res_pred_taken);
  assign pred_taken = pred_valid & is_branch_op(pred_opcode)
                    & bht_predicts_taken(bht_q[pred_idx]);

  assign bht_wr_d = bht_train(bht_q[res_idx], res_taken);

  // Lookups read bht_q directly, so a same-cycle write is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= BHT_RST;
    end else if (train) begin
      bht_q[res_idx] <= bht_wr_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispred_q,  stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (stat_clr) begin
      stat_branches_d = '0;
      stat_mispred_d  = '0;
    end else begin
      if (train && (stat_branches_q != '1))
        stat_branches_d = stat_branches_q + STAT_W'(1);
      if (mispredict && (stat_mispred_q != '1))
        stat_mispred_d = stat_mispred_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

  logic unused_ok;
  assign unused_ok = ^{pred_pc, res_pc};
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;

  logic unused_ok;
  assign unused_ok = ^{pred_pc, res_pc, stat_clr};
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module : tb_branch_predict_unit
// Self-checking bench: vector table plus hand sequences against a BHT model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

  localparam int PC_W   = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;
  localparam int STAT_W = 2;

  localparam logic [4:0] BEQZ = 5'b01100;
  localparam logic [4:0] BNEZ = 5'b01101;
  localparam logic [4:0] BLTZ = 5'b01110;
  localparam logic [4:0] BGEZ = 5'b01111;

  typedef struct {
    logic        pv;
    logic [15:0] ppc;
    logic [4:0]  pop;
    logic        rv;
    logic [15:0] rpc;
    logic [4:0]  rop;
    logic [15:0] rs;
    logic        rpt;
    logic        clr;
    logic        e_pred;
    logic        e_rt;
    logic        e_mp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              pred_valid = 1'b0;
  logic [PC_W-1:0]   pred_pc = '0;
  logic [4:0]        pred_opcode = '0;
  logic              pred_taken;
  logic              res_valid = 1'b0;
  logic [PC_W-1:0]   res_pc = '0;
  logic [4:0]        res_opcode = '0;
  logic [DATA_W-1:0] res_rs = '0;
  logic              res_pred_taken = 1'b0;
  logic              res_taken;
  logic              mispredict;
  logic              stat_clr = 1'b0;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_opcode    (pred_opcode),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_opcode     (res_opcode),
    .res_rs         (res_rs),
    .res_pred_taken (res_pred_taken),
    .res_taken      (res_taken),
    .mispredict     (mispredict),
    .stat_clr       (stat_clr),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   bht_m [16];
  int   br_m = 0;
  int   mp_m = 0;
  vec_t exp_q [$];
  vec_t tbl [12];

  localparam int STAT_MAX = (1 << STAT_W) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic isbr(input logic [4:0] op);
    return (op >= 5'b01100) && (op <= 5'b01111);
  endfunction

  function automatic logic model_pred(input logic [15:0] pc);
    logic [3:0] idx;
    idx = pc[4:1];
    return bht_m[idx] >= 2;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    logic [3:0] idx;
    @(posedge clk);
    #1;
    pred_valid     = v.pv;
    pred_pc        = v.ppc;
    pred_opcode    = v.pop;
    res_valid      = v.rv;
    res_pc         = v.rpc;
    res_opcode     = v.rop;
    res_rs         = v.rs;
    res_pred_taken = v.rpt;
    stat_clr       = v.clr;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.e_pred});
      chk("res_taken",  {31'b0, res_taken},  {31'b0, e.e_rt});
      chk("mispredict", {31'b0, mispredict}, {31'b0, e.e_mp});
      chk("stat_branches", {30'b0, stat_branches}, br_m);
      chk("stat_mispred",  {30'b0, stat_mispred},  mp_m);
      idx = e.rpc[4:1];
      if (e.rv && isbr(e.rop)) begin
        if (e.e_rt) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
        else        bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
      end
`ifdef BRANCH_STATS_EN
      if (e.clr) begin
        br_m = 0;
        mp_m = 0;
      end else begin
        if (e.rv && isbr(e.rop) && br_m < STAT_MAX) br_m++;
        if (e.e_mp && mp_m < STAT_MAX) mp_m++;
      end
`endif
    end
  endtask

  // Lookup with BEQZ at ppc while resolving rop at rpc; pipeline prediction is rpt.
  task automatic seq(input logic [15:0] ppc, input logic [15:0] rpc, input logic [4:0] rop,
                     input logic [15:0] rs, input logic rpt, input logic clr, input logic e_rt);
    vec_t v;
    v.pv = 1'b1; v.ppc = ppc; v.pop = BEQZ;
    v.rv = 1'b1; v.rpc = rpc; v.rop = rop; v.rs = rs; v.rpt = rpt; v.clr = clr;
    v.e_pred = model_pred(ppc);
    v.e_rt   = e_rt;
    v.e_mp   = isbr(rop) && (e_rt != rpt);
    step(v);
  endtask

  task automatic look(input logic [15:0] ppc);
    vec_t v;
    v.pv = 1'b1; v.ppc = ppc; v.pop = BEQZ;
    v.rv = 1'b0; v.rpc = '0; v.rop = '0; v.rs = '0; v.rpt = 1'b0; v.clr = 1'b0;
    v.e_pred = model_pred(ppc);
    v.e_rt = 1'b0;
    v.e_mp = 1'b0;
    step(v);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    pred_valid = 1'b0; res_valid = 1'b0; stat_clr = 1'b0;
    pred_opcode = BEQZ; res_opcode = BEQZ; res_rs = '0; res_pred_taken = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_pred_taken", {31'b0, pred_taken}, 0);
    chk("rst_res_taken",  {31'b0, res_taken},  0);
    chk("rst_mispredict", {31'b0, mispredict}, 0);
    chk("rst_stat_branches", {30'b0, stat_branches}, 0);
    chk("rst_stat_mispred",  {30'b0, stat_mispred},  0);
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    br_m = 0;
    mp_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [4:0] rop, input logic [15:0] rs, input logic rpt,
                              input logic e_rt, input logic e_mp, input int i);
    vec_t v;
    v.pv = 1'b1; v.ppc = 16'h0002; v.pop = BEQZ;
    v.rv = 1'b1; v.rpc = 16'h0104 + 16'(2 * i); v.rop = rop; v.rs = rs; v.rpt = rpt;
    v.clr = 1'b0; v.e_pred = 1'b0; v.e_rt = e_rt; v.e_mp = e_mp;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(BEQZ,     16'h0000, 1'b0, 1'b1, 1'b1, 0);
    tbl[1]  = mk(BNEZ,     16'h0000, 1'b0, 1'b0, 1'b0, 1);
    tbl[2]  = mk(BLTZ,     16'h8000, 1'b0, 1'b1, 1'b1, 2);
    tbl[3]  = mk(BGEZ,     16'h8000, 1'b0, 1'b0, 1'b0, 3);
    tbl[4]  = mk(BNEZ,     16'h0005, 1'b0, 1'b1, 1'b1, 4);
    tbl[5]  = mk(BGEZ,     16'h7FFF, 1'b0, 1'b1, 1'b1, 5);
    tbl[6]  = mk(5'b00000, 16'h1234, 1'b1, 1'b0, 1'b0, 6);
    tbl[7]  = mk(5'b10000, 16'h8000, 1'b1, 1'b0, 1'b0, 7);
    tbl[8]  = mk(BLTZ,     16'h7FFF, 1'b1, 1'b0, 1'b1, 8);
    tbl[9]  = mk(BEQZ,     16'h0001, 1'b0, 1'b0, 1'b0, 9);
    tbl[10] = mk(5'b01011, 16'h0000, 1'b1, 1'b0, 1'b0, 10);
    tbl[11] = mk(BGEZ,     16'hFFFF, 1'b1, 1'b0, 1'b1, 11);

    reset_dut();

    // Fresh entry predicts not-taken; one taken resolve moves it to WT.
    look(16'h0010);
    seq(16'h0002, 16'h0010, BEQZ, 16'h0000, 1'b0, 1'b0, 1'b1);
    look(16'h0010);

    foreach (tbl[i]) step(tbl[i]);

    // Saturation on entry 2 (pc 0x0004), lookup hits the same index each cycle.
    for (int k = 0; k < 5; k++) seq(16'h0004, 16'h0004, BEQZ, 16'h0000, model_pred(16'h0004), 1'b0, 1'b1);
    look(16'h0004);
    seq(16'h0004, 16'h0004, BEQZ, 16'h0001, model_pred(16'h0004), 1'b0, 1'b0);
    look(16'h0004);
    for (int k = 0; k < 3; k++) seq(16'h0004, 16'h0004, BEQZ, 16'h0001, model_pred(16'h0004), 1'b0, 1'b0);
    look(16'h0004);
    seq(16'h0004, 16'h0004, BEQZ, 16'h0000, model_pred(16'h0004), 1'b0, 1'b1);
    look(16'h0004);
    seq(16'h0004, 16'h0004, BEQZ, 16'h0000, model_pred(16'h0004), 1'b0, 1'b1);
    look(16'h0004);

    // Non-branches on a WT entry must neither flag nor train.
    seq(16'h0004, 16'h0004, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0);
    seq(16'h0004, 16'h0004, 5'b00000, 16'h8001, 1'b1, 1'b0, 1'b0);
    look(16'h0004);

    // Reset discards training; same-cycle collision sees the pre-update value.
    reset_dut();
    seq(16'h0010, 16'h0010, BEQZ, 16'h0000, 1'b0, 1'b0, 1'b1);
    look(16'h0010);

    // Statistics: saturation of the branch count, then clear beating an increment.
    reset_dut();
    for (int k = 0; k < 3; k++) seq(16'h0020, 16'h0020, BEQZ, 16'h0001, 1'b0, 1'b0, 1'b0);
    seq(16'h0020, 16'h0020, BEQZ, 16'h0000, 1'b0, 1'b0, 1'b1);
    look(16'h0020);
    seq(16'h0020, 16'h0020, BEQZ, 16'h0000, 1'b0, 1'b1, 1'b1);
    look(16'h0020);
    look(16'h0020);

    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    stat_clr   = 1'b0;
    @(negedge clk);
    chk("idle_pred_taken", {31'b0, pred_taken}, 0);
    chk("idle_mispredict", {31'b0, mispredict}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
